// File: rtl/rf_writeback_queue_pkg.sv
// rfwb_pkg: shared constants and types for the register-file writeback queue.
//   ADDR_W / DATA_W : register address and data widths
//   NUM_REGS        : number of implemented registers (higher addresses are dropped)
//   wb_entry_t      : one queued write {wreg, data}
//   state_t         : flush-drain FSM states
package rfwb_pkg;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;

  typedef struct packed {
    logic [ADDR_W-1:0] wreg;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/rf_writeback_queue_if.sv
// rf_writeback_queue_if: valid/ready writeback request channel.
//   in_valid : request valid (master -> slave)
//   in_ready : queue can accept (slave -> master)
//   in_reg   : destination register
//   in_data  : data to write
interface rf_writeback_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_reg;
  logic [DW-1:0] in_data;

  modport master (output in_valid, output in_reg, output in_data, input in_ready);
  modport slave  (input in_valid, input in_reg, input in_data, output in_ready);
endinterface

// File: rtl/rf_writeback_queue_fifo.sv
// rfwb_fifo: circular FIFO of pending register writes.
//   clk, rst_n         : clock, async active-low reset (empties the queue)
//   push, push_entry   : enqueue at the tail
//   pop, head          : dequeue from the head; head is valid while count != 0
//   full, count        : occupancy
//   age_valid/age_entry: entries in age order (index 0 = oldest) for forwarding
module rfwb_fifo
  import rfwb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [DEPTH-1:0]         age_valid,
  output wb_entry_t                age_entry [DEPTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t       mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   age_idx [DEPTH];

  // Storage needs no reset: count alone defines which slots are live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // DEPTH is a power of two, so pointer increments wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];
  assign full = (count == CW'(DEPTH));

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      age_idx[i]   = rd_ptr + PW'(i);
      age_entry[i] = mem[age_idx[i]];
      age_valid[i] = (CW'(i) < count);
    end
  end
endmodule

// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: buffers register-file writebacks and drains them one per
// cycle into the RF write port, forwarding pending data to decode readers.
//   CLK, RST_N              : clock, async active-low reset
//   req (slave)             : in_valid/in_ready/in_reg/in_data request channel
//   rf_stall                : RF port busy, hold the head
//   RegWre/WriteReg/WriteData : registered RF write port (RF captures on negedge)
//   rs, rt / fwdN_hit, fwdN_data : forwarding of youngest pending write
//   drain_req / drain_done  : flush-drain handshake (done is a one-cycle pulse)
//   count                   : queued entries
//   drop_cnt                : saturating count of dropped requests; built only
//                             when RFWB_DROP_CNT_EN is defined, else tied to 0
module rf_writeback_queue
  import rfwb_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NUM_REGS = rfwb_pkg::NUM_REGS
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  rf_writeback_queue_if.slave    req,
  input  logic                   rf_stall,
  output logic                   RegWre,
  output logic [ADDR_W-1:0]      WriteReg,
  output logic [DATA_W-1:0]      WriteData,
  input  logic [ADDR_W-1:0]      rs,
  input  logic [ADDR_W-1:0]      rt,
  output logic                   fwd1_hit,
  output logic                   fwd2_hit,
  output logic [DATA_W-1:0]      fwd1_data,
  output logic [DATA_W-1:0]      fwd2_data,
  input  logic                   drain_req,
  output logic                   drain_done,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             drop_cnt
);
  state_t          state, state_nxt;
  wb_entry_t       head;
  wb_entry_t       age_entry [DEPTH];
  logic [DEPTH-1:0] age_valid;
  logic            full, accept, in_range, push, pop;

  assign req.in_ready = !full && (state == ST_RUN);
  assign accept       = req.in_valid && req.in_ready;
  assign in_range     = (req.in_reg != '0) && (int'(req.in_reg) < NUM_REGS);
  assign push         = accept && in_range;
  assign pop          = (count != '0) && !rf_stall;

  rfwb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (CLK),
    .rst_n      (RST_N),
    .push       (push),
    .push_entry ('{wreg: req.in_reg, data: req.in_data}),
    .pop        (pop),
    .head       (head),
    .full       (full),
    .count      (count),
    .age_valid  (age_valid),
    .age_entry  (age_entry)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWre    <= 1'b0;
      WriteReg  <= '0;
      WriteData <= '0;
    end else if (pop) begin
      RegWre    <= 1'b1;
      WriteReg  <= head.wreg;
      WriteData <= head.data;
    end else begin
      RegWre    <= 1'b0;
    end
  end

  // Search oldest to youngest so later matches override: output stage first,
  // then FIFO head to tail.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (RegWre && WriteReg == rs) begin
      fwd1_hit  = 1'b1;
      fwd1_data = WriteData;
    end
    if (RegWre && WriteReg == rt) begin
      fwd2_hit  = 1'b1;
      fwd2_data = WriteData;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_valid[i] && age_entry[i].wreg == rs) begin
        fwd1_hit  = 1'b1;
        fwd1_data = age_entry[i].data;
      end
      if (age_valid[i] && age_entry[i].wreg == rt) begin
        fwd2_hit  = 1'b1;
        fwd2_data = age_entry[i].data;
      end
    end
    // Register 0 is hardwired; never forward it.
    if (rs == '0) begin
      fwd1_hit  = 1'b0;
      fwd1_data = '0;
    end
    if (rt == '0) begin
      fwd2_hit  = 1'b0;
      fwd2_data = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= ST_RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    drain_done = 1'b0;
    case (state)
      ST_RUN:   if (drain_req) state_nxt = ST_DRAIN;
      ST_DRAIN: if (count == '0 && !RegWre) state_nxt = ST_DONE;
      ST_DONE: begin
        drain_done = 1'b1;
        state_nxt  = ST_RUN;
      end
      default:  state_nxt = ST_RUN;
    endcase
  end

`ifdef RFWB_DROP_CNT_EN
  logic       drop;
  logic [7:0] drop_q;
  assign drop = accept && !in_range;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)                      drop_q <= '0;
    else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
  end
  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif
endmodule

// File: tb/tb_rf_writeback_queue.sv
// tb_rf_writeback_queue: directed bench for rf_writeback_queue with a negedge
// register-file model fed by the DUT write port.
module tb_rf_writeback_queue;
  import rfwb_pkg::*;

  localparam int DEPTH = 4;

  logic              CLK;
  logic              RST_N;
  logic              rf_stall;
  logic              RegWre;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic [ADDR_W-1:0] rs, rt;
  logic              fwd1_hit, fwd2_hit;
  logic [DATA_W-1:0] fwd1_data, fwd2_data;
  logic              drain_req;
  logic              drain_done;
  logic [2:0]        count;
  logic [7:0]        drop_cnt;

  rf_writeback_queue_if #(.AW(ADDR_W), .DW(DATA_W)) req_if ();

  rf_writeback_queue #(.DEPTH(DEPTH), .NUM_REGS(16)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .req        (req_if),
    .rf_stall   (rf_stall),
    .RegWre     (RegWre),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .rs         (rs),
    .rt         (rt),
    .fwd1_hit   (fwd1_hit),
    .fwd2_hit   (fwd2_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_data  (fwd2_data),
    .drain_req  (drain_req),
    .drain_done (drain_done),
    .count      (count),
    .drop_cnt   (drop_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Register file model: writes on negedge when enabled and address != 0.
  logic [DATA_W-1:0] rf [16];
  int                wr_count;
  always @(negedge CLK) begin
    if (RegWre === 1'b1 && WriteReg != '0 && WriteReg < 5'd16) begin
      rf[WriteReg[3:0]] <= WriteData;
      wr_count          <= wr_count + 1;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    req_if.in_valid = 1'b1;
    req_if.in_reg   = r;
    req_if.in_data  = d;
    tick();
    req_if.in_valid = 1'b0;
  endtask

  initial begin
    int base;
    int c;
    for (int i = 0; i < 16; i++) rf[i] = '0;
    wr_count        = 0;
    RST_N           = 1'b0;
    rf_stall        = 1'b0;
    rs              = '0;
    rt              = '0;
    drain_req       = 1'b0;
    req_if.in_valid = 1'b0;
    req_if.in_reg   = '0;
    req_if.in_data  = '0;
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    tick();

    // Reset state
    chk("rst_regwre",  RegWre, 0);
    chk("rst_writereg", WriteReg, 0);
    chk("rst_writedata", WriteData, 0);
    chk("rst_count", count, 0);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_drain_done", drain_done, 0);
    chk("rst_in_ready", req_if.in_ready, 1);

    // Single write, latency of one edge
    push(5'd5, 32'hDEADBEEF);
    chk("t1_count_after_push", count, 1);
    chk("t1_no_bypass", RegWre, 0);
    tick();
    chk("t1_regwre", RegWre, 1);
    chk("t1_writereg", WriteReg, 5);
    chk("t1_writedata", WriteData, 32'hDEADBEEF);
    chk("t1_count_empty", count, 0);
    @(negedge CLK);
    #1;
    chk("t1_rf5", rf[5], 32'hDEADBEEF);
    tick();
    chk("t1_regwre_low", RegWre, 0);

    // Fill under stall, then drain in order
    rf_stall = 1'b1;
    push(5'd1, 32'h11);
    push(5'd2, 32'h22);
    push(5'd3, 32'h33);
    chk("t2_ready_at_3", req_if.in_ready, 1);
    push(5'd4, 32'h44);
    chk("t2_count_full", count, 4);
    chk("t2_ready_full", req_if.in_ready, 0);
    chk("t2_no_write_stalled", RegWre, 0);
    rf_stall = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t2_drain_regwre", RegWre, 1);
      chk("t2_drain_order", WriteReg, i);
      chk("t2_drain_data", WriteData, 32'h11 * i);
    end
    tick();
    chk("t2_regwre_low", RegWre, 0);
    chk("t2_rf1", rf[1], 32'h11);
    chk("t2_rf4", rf[4], 32'h44);

    // Forwarding: youngest pending wins
    rs = 5'd7;
    rt = 5'd3;
    rf_stall = 1'b1;
    push(5'd7, 32'd1);
    chk("t3_fwd_one", fwd1_data, 1);
    push(5'd7, 32'd2);
    chk("t3_fwd1_hit", fwd1_hit, 1);
    chk("t3_fwd1_data", fwd1_data, 2);
    chk("t3_fwd2_nohit", fwd2_hit, 0);
    chk("t3_fwd2_zero", fwd2_data, 0);
    rf_stall = 1'b0;
    tick();
    chk("t3_fwd_out_vs_fifo", fwd1_data, 2);
    tick();
    chk("t3_fwd_out_stage_hit", fwd1_hit, 1);
    chk("t3_fwd_out_stage_data", fwd1_data, 2);
    tick();
    chk("t3_fwd_clear_hit", fwd1_hit, 0);
    chk("t3_fwd_clear_data", fwd1_data, 0);
    chk("t3_rf7", rf[7], 2);
    rs = '0;
    rt = '0;

    // Dropped requests
    base = wr_count;
    push(5'd0, 32'h55);
    chk("t4_count_r0", count, 0);
    push(5'd20, 32'h66);
    chk("t4_count_r20", count, 0);
    tick();
    chk("t4_no_regwre", RegWre, 0);
    chk("t4_no_writes", wr_count - base, 0);
`ifdef RFWB_DROP_CNT_EN
    chk("t4_drop_cnt", drop_cnt, 2);
`else
    chk("t4_drop_cnt", drop_cnt, 0);
`endif

    // Drain handshake with 3 queued
    rf_stall = 1'b1;
    push(5'd10, 32'hA0);
    push(5'd11, 32'hA1);
    push(5'd12, 32'hA2);
    chk("t5_count3", count, 3);
    base      = wr_count;
    rf_stall  = 1'b0;
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("t5_ready_in_drain", req_if.in_ready, 0);
    c = 0;
    while (drain_done !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    chk("t5_drain_done_seen", drain_done, 1);
    chk("t5_writes", wr_count - base, 3);
    chk("t5_rf12", rf[12], 32'hA2);
    tick();
    chk("t5_done_one_cycle", drain_done, 0);
    chk("t5_ready_back", req_if.in_ready, 1);

    // Drain request on empty queue
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    chk("t5e_not_yet", drain_done, 0);
    tick();
    chk("t5e_done", drain_done, 1);
    tick();
    chk("t5e_done_clear", drain_done, 0);

    // Async reset with pending entries
    rf_stall = 1'b1;
    push(5'd13, 32'hB1);
    push(5'd14, 32'hB2);
    rf_stall = 1'b0;
    tick();
    chk("t6_regwre_before", RegWre, 1);
    base = wr_count;
    #2 RST_N = 1'b0;
    #1;
    chk("t6_regwre_async", RegWre, 0);
    chk("t6_count_async", count, 0);
    repeat (2) @(posedge CLK);
    #3 RST_N = 1'b1;
    repeat (4) tick();
    chk("t6_no_writes", wr_count - base, 0);
    chk("t6_rf13", rf[13], 0);
    chk("t6_rf14", rf[14], 0);
    chk("t6_count_after", count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
